// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the I2S receive path: sample width, the receiver
// state enumeration, the default FIFO depth and a small helper that
// left-justifies a partially received sample.
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Receiver states, in the order a word normally walks through them.
  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    WAIT_CH = 3'd1,
    SKIP    = 3'd2,
    SHIFT   = 3'd3,
    HOLD    = 3'd4
  } rx_state_t;

  // A word cut short by a WS change keeps its received bits at the top of
  // the sample.  The unfilled LSBs come out as zero.
  function automatic logic [SAMPLE_W-1:0] left_justify(
    input logic [SAMPLE_W-1:0] bits,
    input logic [4:0]          nbits
  );
    return bits << (5'd16 - nbits);
  endfunction

endpackage

// File: rtl/audio_i2s_rx_if.sv
// ---------------------------------------------------------------------------
// audio_i2s_rx_if
// Sample stream leaving the I2S receiver.
//   Data_OUT   : signed Q1.15 sample at the FIFO head, zero when not valid
//   Data_VALID : FIFO not empty
//   Data_READY : consumer takes the head sample on this CLK edge
//   OVERRUN    : one-CLK pulse when a finished sample was dropped
// master = receiver side, slave = consumer side (e.g. IIR_Filter).
// ---------------------------------------------------------------------------
interface audio_i2s_rx_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] Data_OUT;
  logic                Data_VALID;
  logic                Data_READY;
  logic                OVERRUN;

  modport master (
    output Data_OUT,
    output Data_VALID,
    output OVERRUN,
    input  Data_READY
  );

  modport slave (
    input  Data_OUT,
    input  Data_VALID,
    input  OVERRUN,
    output Data_READY
  );

endinterface

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Small synchronous first-in first-out buffer for finished audio samples.
//   CLK, RESET : system clock, synchronous active-high reset
//   push       : store push_data this cycle (dropped when full and no pop)
//   push_data  : sample to store
//   pop        : consumer takes the head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
//   valid      : FIFO holds at least one entry
//   overrun    : one-cycle pulse after a push was dropped
// DEPTH must be a power of two from 2 to 16.
// ---------------------------------------------------------------------------
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO can still accept a push when its head leaves on the same
  // edge.  The write then lands in the slot being vacated.
  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  // Storage array.  It has no reset: the pointers and count decide what is
  // live, so stale contents are never visible.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.  The count is
  // one bit wider than the pointers so that full and empty stay distinct.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun <= push & full & ~pop;
    end
  end

  // The head is exposed only while valid.  Otherwise the output is zero.
  always_comb begin
    valid    = ~empty;
    pop_data = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/audio_i2s_rx.sv
// ---------------------------------------------------------------------------
// audio_i2s_rx
// Captures one channel of an I2S stream into 16-bit samples and buffers them
// for the downstream filter.
//   CLK, RESET : system clock, synchronous active-high reset
//   SCK, WS, SD: I2S bit clock, word select and serial data, all
//                asynchronous to CLK (SCK at most CLK/8)
//   bus        : sample stream (Data_OUT / Data_VALID / Data_READY / OVERRUN)
// CHANNEL picks the channel: 0 = left (WS low), 1 = right (WS high).
// FIFO_DEPTH is a power of two from 2 to 16.
// ---------------------------------------------------------------------------
module audio_i2s_rx
  import audio_pkg::*;
#(
  parameter int CHANNEL    = 0,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCK,
  input  logic              WS,
  input  logic              SD,
  audio_i2s_rx_if.master    bus
);

  localparam logic SEL_WS = (CHANNEL != 0);

  logic [1:0]          sck_s;
  logic [1:0]          ws_s;
  logic [1:0]          sd_s;
  logic                sck_d;
  logic                ws_prev;
  logic                sck_rise;
  logic                ws_chg;

  rx_state_t           state;
  rx_state_t           state_nxt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] shreg_nxt;
  logic [4:0]          bit_cnt;
  logic [4:0]          bit_cnt_nxt;
  logic                push_req;
  logic                push_req_nxt;
  logic [SAMPLE_W-1:0] push_data;
  logic [SAMPLE_W-1:0] push_data_nxt;

  // Two-flop synchronizers on every serial input.  sck_d holds the previous
  // synchronized SCK so that a rising edge can be found.  ws_prev holds the
  // WS level seen at the last SCK rising edge.  ws_prev resets low, so a WS
  // line that is already high can look like a change on the first edge.
  // That only moves SYNC to WAIT_CH, which still waits for a real change
  // before capturing, so no misaligned word can slip through.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_s   <= '0;
      ws_s    <= '0;
      sd_s    <= '0;
      sck_d   <= 1'b0;
      ws_prev <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], SCK};
      ws_s  <= {ws_s[0], WS};
      sd_s  <= {sd_s[0], SD};
      sck_d <= sck_s[1];
      if (sck_rise) begin
        ws_prev <= ws_s[1];
      end
    end
  end

  always_comb begin
    sck_rise = sck_s[1] & ~sck_d;
    ws_chg   = sck_rise & (ws_s[1] != ws_prev);
  end

  // Receiver state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers.  A finished sample sits in push_data with push_req
  // set for one cycle, so it reaches the FIFO on the CLK edge after the
  // completing SCK edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      push_req  <= push_req_nxt;
      push_data <= push_data_nxt;
    end
  end

  // Next-state and datapath control.  The SCK edge where WS changes carries
  // the last bit of the previous word; this is the I2S one-bit delay.  That
  // edge is consumed by WAIT_CH, so SKIP only clears the shift state and
  // hands over to SHIFT for the MSB on the following edge.  SCK edges are
  // at least 8 CLKs apart, so SKIP never overlaps an edge.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    push_req_nxt  = 1'b0;
    push_data_nxt = push_data;
    case (state)
      SYNC: begin
        if (ws_chg) begin
          state_nxt = WAIT_CH;
        end
      end
      WAIT_CH: begin
        if (ws_chg && (ws_s[1] == SEL_WS)) begin
          state_nxt = SKIP;
        end
      end
      SKIP: begin
        shreg_nxt   = '0;
        bit_cnt_nxt = '0;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        if (ws_chg) begin
          push_req_nxt  = 1'b1;
          push_data_nxt = left_justify(shreg, bit_cnt);
          state_nxt     = WAIT_CH;
        end else if (sck_rise) begin
          shreg_nxt   = {shreg[SAMPLE_W-2:0], sd_s[1]};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            push_req_nxt  = 1'b1;
            push_data_nxt = {shreg[SAMPLE_W-2:0], sd_s[1]};
            state_nxt     = HOLD;
          end
        end
      end
      HOLD: begin
        if (ws_chg) begin
          state_nxt = WAIT_CH;
        end
      end
      default: begin
        state_nxt = SYNC;
      end
    endcase
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push_req),
    .push_data (push_data),
    .pop       (bus.Data_READY),
    .pop_data  (bus.Data_OUT),
    .valid     (bus.Data_VALID),
    .overrun   (bus.OVERRUN)
  );

endmodule

// File: tb/tb_audio_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_audio_i2s_rx
// Directed bench for audio_i2s_rx.  A left-channel receiver (dut0) and a
// right-channel receiver (dut1) listen to the same serial lines.  Samples
// popped from each are logged at the falling CLK edge and compared against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_audio_i2s_rx;
  import audio_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  logic SCK;
  logic WS;
  logic SD;

  audio_i2s_rx_if bus0 ();
  audio_i2s_rx_if bus1 ();

  audio_i2s_rx #(.CHANNEL(0), .FIFO_DEPTH(4)) dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .SCK   (SCK),
    .WS    (WS),
    .SD    (SD),
    .bus   (bus0)
  );

  audio_i2s_rx #(.CHANNEL(1), .FIFO_DEPTH(4)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .SCK   (SCK),
    .WS    (WS),
    .SD    (SD),
    .bus   (bus1)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int vcnt0 = 0;
  int ovf0  = 0;

  // Log every accepted sample, every valid cycle and every overrun pulse
  // at the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (bus0.Data_VALID) begin
      vcnt0++;
      if (bus0.Data_READY) q0.push_back(bus0.Data_OUT);
    end
    if (bus0.OVERRUN) ovf0++;
    if (bus1.Data_VALID && bus1.Data_READY) q1.push_back(bus1.Data_OUT);
  end

  function automatic logic [15:0] peek0(input int i);
    return (i < q0.size()) ? q0[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] peek1(input int i);
    return (i < q1.size()) ? q1[i] : 16'hxxxx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One serial bit: WS and SD change with SCK low, and the receiver samples
  // on the SCK rise.  The SCK period is 8 CLKs.
  task automatic sendBit(input logic ws, input logic b);
    @(negedge CLK);
    SCK = 1'b0;
    WS  = ws;
    SD  = b;
    repeat (3) @(negedge CLK);
    SCK = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  // One I2S word.  The first bit carries the new WS level; this is the
  // delay slot.  It is followed by the top nbits of data, MSB first.  With
  // popAtEnd set, dut0's consumer takes one sample exactly on the CLK edge
  // where the final bit's sample enters the FIFO.  That edge is the fourth
  // rising CLK edge after the SCK rise: two synchronizer flops, the state
  // machine register, then the FIFO write.
  task automatic applyStimulus(input logic ws, input logic [15:0] data,
                               input int nbits, input bit popAtEnd);
    sendBit(ws, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (popAtEnd && (i == nbits - 1)) begin
        @(negedge CLK);
        SCK = 1'b0;
        WS  = ws;
        SD  = data[15-i];
        repeat (3) @(negedge CLK);
        SCK = 1'b1;
        repeat (3) @(posedge CLK);
        #1 bus0.Data_READY = 1'b1;
        @(posedge CLK);
        #1 bus0.Data_READY = 1'b0;
        @(negedge CLK);
      end else begin
        sendBit(ws, data[15-i]);
      end
    end
  endtask

  initial begin
    SCK = 1'b0;
    WS  = 1'b0;
    SD  = 1'b0;
    RESET = 1'b1;
    bus0.Data_READY = 1'b0;
    bus1.Data_READY = 1'b1;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rst_valid0", bus0.Data_VALID, 1'b0);
    checkOutput("rst_data0", bus0.Data_OUT, 16'h0000);
    checkOutput("rst_overrun0", bus0.OVERRUN, 1'b0);
    checkOutput("rst_valid1", bus1.Data_VALID, 1'b0);

    // The first WS change only brings both receivers out of SYNC.
    applyStimulus(1'b1, 16'h0000, 16, 1'b0);

    // A left word flows straight through while the consumer is ready.
    q0.delete();
    vcnt0 = 0;
    @(posedge CLK);
    #1 bus0.Data_READY = 1'b1;
    applyStimulus(1'b0, 16'h1000, 16, 1'b0);
    repeat (8) @(negedge CLK);
    checkOutput("left_count", q0.size(), 1);
    checkOutput("left_data", peek0(0), 16'h1000);
    checkOutput("left_valid_cycles", vcnt0, 1);

    // A right word is ignored by the left receiver and taken by the right one.
    q0.delete();
    q1.delete();
    vcnt0 = 0;
    applyStimulus(1'b1, 16'h0CCC, 16, 1'b0);
    repeat (8) @(negedge CLK);
    checkOutput("right_ignored_valid", vcnt0, 0);
    checkOutput("right_count", q1.size(), 1);
    checkOutput("right_data", peek1(0), 16'h0CCC);

    // A 12-bit left word ends early and is left-justified.
    q0.delete();
    q1.delete();
    applyStimulus(1'b0, 16'hABC0, 12, 1'b0);
    applyStimulus(1'b1, 16'h1234, 16, 1'b0);
    repeat (8) @(negedge CLK);
    checkOutput("short_count", q0.size(), 1);
    checkOutput("short_data", peek0(0), 16'hABC0);
    checkOutput("short_right_count", q1.size(), 1);
    checkOutput("short_right_data", peek1(0), 16'h1234);

    // Five left words with the consumer stalled: the fifth one overruns.
    @(posedge CLK);
    #1 bus0.Data_READY = 1'b0;
    q0.delete();
    ovf0 = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 16'(k), 16, 1'b0);
      applyStimulus(1'b1, 16'h0000, 16, 1'b0);
    end
    checkOutput("ovr_before_fifth", ovf0, 0);
    applyStimulus(1'b0, 16'h0005, 16, 1'b0);
    applyStimulus(1'b1, 16'h0000, 16, 1'b0);
    checkOutput("ovr_fifth", ovf0, 1);
    checkOutput("ovr_head_held", bus0.Data_OUT, 16'h0001);
    checkOutput("ovr_no_pop", q0.size(), 0);
    @(posedge CLK);
    #1 bus0.Data_READY = 1'b1;
    repeat (10) @(negedge CLK);
    checkOutput("ovr_read_count", q0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovr_read[%0d]", i), peek0(i), 16'(i + 1));
    end
    checkOutput("drained_valid", bus0.Data_VALID, 1'b0);
    checkOutput("drained_data", bus0.Data_OUT, 16'h0000);

    // A full FIFO with a pop on the same edge as a new push: no overrun.
    @(posedge CLK);
    #1 bus0.Data_READY = 1'b0;
    q0.delete();
    ovf0 = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 16'(k * 17), 16, 1'b0);
      applyStimulus(1'b1, 16'h0000, 16, 1'b0);
    end
    applyStimulus(1'b0, 16'h0055, 16, 1'b1);
    applyStimulus(1'b1, 16'h0000, 16, 1'b0);
    checkOutput("simul_no_overrun", ovf0, 0);
    checkOutput("simul_pop_count", q0.size(), 1);
    checkOutput("simul_pop_data", peek0(0), 16'h0011);
    @(posedge CLK);
    #1 bus0.Data_READY = 1'b1;
    repeat (10) @(negedge CLK);
    checkOutput("simul_total", q0.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("simul_order[%0d]", i), peek0(i), 16'((i + 1) * 17));
    end

    // Reset in the middle of a left word drops it.  The receivers resync
    // on a fresh WS change.
    q0.delete();
    q1.delete();
    applyStimulus(1'b0, 16'hA5A5, 8, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checkOutput("midrst_valid", bus0.Data_VALID, 1'b0);
    applyStimulus(1'b1, 16'h1111, 16, 1'b0);
    applyStimulus(1'b0, 16'h8000, 16, 1'b0);
    applyStimulus(1'b1, 16'h2222, 16, 1'b0);
    repeat (8) @(negedge CLK);
    checkOutput("midrst_count", q0.size(), 1);
    checkOutput("midrst_data", peek0(0), 16'h8000);
    checkOutput("midrst_right_count", q1.size(), 1);
    checkOutput("midrst_right_data", peek1(0), 16'h2222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_i2s_rx.md
AUDIO_I2S_RX -- requirements
Module: audio_i2s_rx

Interface
REQ-001 Parameter CHANNEL, default 0, selects the captured channel: 0 = left (WS low), 1 = right (WS high).
REQ-002 Parameter FIFO_DEPTH, default 4, sets the number of 16-bit output FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 CLK  input  1  single system clock for all logic; rising edge active.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 SCK  input  1  serial bit clock, asynchronous to CLK, at most CLK/8.
REQ-006 WS  input  1  word select, asynchronous to CLK.
REQ-007 SD  input  1  serial data, MSB first, asynchronous to CLK.
REQ-008 Data_OUT  output  16  signed Q1.15 sample at the FIFO head; this port feeds Data_IN of the downstream IIR_Filter.
REQ-009 Data_VALID  output  1  high when the FIFO is not empty.
REQ-010 Data_READY  input  1  consumer accepts the head sample; a pop occurs only when Data_VALID and Data_READY are both high on a CLK edge.
REQ-011 OVERRUN  output  1  one-CLK pulse when a completed sample is dropped because the FIFO is full.

Function
REQ-012 SCK, WS and SD shall each pass through a 2-flop synchronizer before any use.
REQ-013 An SCK rising edge shall be detected from the synchronized SCK as the current sample high and the previous sample low; all serial sampling occurs only on such edges.
REQ-014 State machine states: SYNC, WAIT_CH, SKIP, SHIFT, HOLD.
REQ-015 SYNC is entered after reset. It moves to WAIT_CH on the first WS change sampled at an SCK rising edge; no data is captured before that change.
REQ-016 WAIT_CH moves to SKIP when WS changes to the level selected by CHANNEL.
REQ-017 SKIP ignores exactly one SCK rising edge (the I2S one-bit delay), clears the shift register and bit counter, then moves to SHIFT.
REQ-018 SHIFT shifts SD into the shift register MSB first, one bit per SCK rising edge, and counts bits from 0 to 16.
REQ-019 When 16 bits have been shifted, the sample is complete and the state moves to HOLD; further bits in that word are ignored.
REQ-020 If WS changes while in SHIFT with fewer than 16 bits received, the sample is complete with the received bits left-justified and the unfilled LSBs set to zero; the state moves to WAIT_CH.
REQ-021 HOLD moves to WAIT_CH on the next WS change.
REQ-022 A completed sample is pushed into the FIFO on the CLK cycle after the completing SCK edge is detected.
REQ-023 Latency: Data_VALID rises 1 CLK after the push when the FIFO was empty.
REQ-024 FIFO behaviour: first-in first-out, and Data_OUT holds its value while Data_VALID is high and Data_READY is low.
REQ-025 Push and pop in the same cycle shall both succeed when full or empty permits; a push into a FIFO that is full and being popped in that cycle shall succeed.
REQ-026 A push into a full FIFO without a simultaneous pop shall be discarded, FIFO contents shall be unchanged, and OVERRUN shall pulse for 1 CLK.
REQ-027 FIFO pointers shall wrap modulo FIFO_DEPTH, with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-028 Data_OUT shall be 0 whenever Data_VALID is low.

Reset
REQ-029 While RESET is high on a CLK edge: state = SYNC; FIFO emptied; shift register, bit counter and synchronizers cleared; Data_OUT = 0, Data_VALID = 0, OVERRUN = 0.
REQ-030 Asserting RESET mid-word shall discard the partial sample, and the next capture shall wait for a fresh WS change.

Structure
REQ-031 The shared package audio_pkg shall hold SAMPLE_W = 16, the state enumeration, and the default FIFO_DEPTH.
REQ-032 The FIFO shall be a separate sub-module, sample_fifo, parameterized by width and depth; the serial front end and state machine remain in audio_i2s_rx.

Verification
REQ-033 Left word 16'h1000 with CHANNEL = 0 and Data_READY = 1 -> Data_OUT = 16'h1000 and Data_VALID high for 1 CLK.
REQ-034 Right word 16'h0CCC sent while CHANNEL = 0 -> no push and Data_VALID stays low; with CHANNEL = 1 -> Data_OUT = 16'h0CCC.
REQ-035 WS toggles after 12 bits of 12'hABC -> Data_OUT = 16'hABC0.
REQ-036 Data_READY = 0 with 5 left words 16'h0001..16'h0005 and depth 4 -> OVERRUN pulses once on the 5th word; with Data_READY then high, the reads are 0001, 0002, 0003, 0004.
REQ-037 RESET asserted after 8 bits of a word -> no sample is produced from that word; the next full word 16'h8000 is read as 16'h8000.
REQ-038 FIFO full while Data_READY = 1 and a new word completes in the same cycle as a pop -> no OVERRUN, and order is preserved.
